mem2d_param: RTL and testbench
==============================

# mem2d_param

Parametrised, clocked two-dimensional memory addressed by (X, Y) coordinates, with a registered read port, a self-clearing initialisation sequencer and a hardware row-fill mode. It is the general-purpose storage tile for frame and line buffers in the design. Host logic drives single-cell reads and writes directly, and issues one-command row fills without looping over X.

## Interface
- DATA_W, default 8: width of each cell.
- X_W, default 6: column address width; row length is 2^X_W.
- Y_W, default 5: row address width; row count is 2^Y_W.
- CLEAR_VAL, default 0: value written to every cell by the clear sequencer, truncated to DATA_W.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset; starts the clear sequence.
- addr_x  in  X_W  column address.
- addr_y  in  Y_W  row address.
- data_in  in  DATA_W  write and fill data.
- wr  in  1  single-cell write strobe.
- rd  in  1  single-cell read strobe.
- fill_row  in  1  fill row addr_y with data_in.
- data_out  out  DATA_W  registered read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse; data_out is updated this cycle.
- busy  out  1  high during CLEAR or FILL; all commands are ignored while high.

## Operation
- Storage: 2^(X_W+Y_W) cells. Linear index is {addr_y, addr_x}, row-major, so Y selects the row.
- FSM states: CLEAR, IDLE, FILL.
- CLEAR:
  - Entered whenever rst=1, from any state, including mid-FILL. An aborted fill is not completed.
  - While rst=1: clear counter is held at 0, busy=1, no writes.
  - Each edge with rst=0 writes CLEAR_VAL to the cell at the counter index, then increments the counter.
  - After the last index (all ones) is written, go to IDLE.
- IDLE, with commands sampled on each rising edge:
  - wr=1: mem[{addr_y,addr_x}] <= data_in.
  - rd=1: data_out <= mem[{addr_y,addr_x}] and rd_valid=1 on the next cycle.
  - rd and wr to the same cell in the same cycle are read-first: data_out returns the old contents.
  - fill_row=1: latch addr_y and data_in, set the column counter to 0, go to FILL.
  - fill_row has priority over wr; a wr in the same cycle is dropped.
  - rd in the same cycle as fill_row is still serviced, and returns the pre-fill contents.
- FILL:
  - Each cycle writes the latched data to {latched_y, col} and increments col.
  - After col reaches 2^X_W-1 is written, go to IDLE.
  - Input changes during FILL have no effect.
- Commands (wr, rd, fill_row) presented while busy=1 are dropped silently and are not queued.

## Timing
- Reset values: data_out=0, rd_valid=0, busy=1, state=CLEAR, counters=0. Memory contents are undefined until CLEAR completes.
- Clear duration: busy stays high for exactly 2^(X_W+Y_W) edges after the first edge with rst=0.
  - busy=0 from the edge that writes the last cell.
  - The next edge accepts commands.
  - With default parameters this is 2048 cycles.
- Read latency is 1 cycle: rd sampled at edge N gives data_out and rd_valid=1 after edge N. rd_valid drops after edge N+1 unless rd is held.
- Back-to-back reads on consecutive cycles give rd_valid continuously high, with data_out updating every cycle.
- Write latency is 1 cycle: a rd of the same cell one cycle after wr returns the new data.
- Fill timing:
  - fill_row sampled at edge N sets busy=1 after edge N.
  - Cells are written at edges N+1 through N+2^X_W.
  - busy=0 after edge N+2^X_W.
  - A command at edge N+2^X_W+1 is accepted.
- Wrap-around: counters wrap naturally at their width. The terminal count is detected explicitly, and no extra write occurs.
- rst asserted at any edge takes effect at that same edge:
  - busy=1 and rd_valid=0 after that edge.
  - A pending fill is discarded.

## Test plan
- Reset/clear: use X_W=2, Y_W=2, CLEAR_VAL=8'h5A. Hold rst 3 cycles, release, pre-poison memory via backdoor. Required: busy high exactly 16 cycles, then every cell reads 8'h5A.
- Write/read: defaults, after clear. wr data_in=8'hAA at x=6'd10, y=5'd5; next cycle rd the same address. Required: rd_valid one cycle later, data_out=8'hAA, neighbouring cell (x=11, y=5) reads CLEAR_VAL.
- Read-first collision: cell holds 8'h11. Same-cycle wr 8'h22 and rd of that cell. Required: data_out=8'h11; a following rd returns 8'h22.
- Row fill: fill_row with y=5'd3, data_in=8'hC3. Required: busy high exactly 64 cycles; all 64 cells of row 3 read 8'hC3; rows 2 and 4 are unchanged. A wr issued mid-fill is ignored.
- Priority: fill_row and wr (x=0, y=7, 8'hFF) in the same cycle. Required: row filled, and cell (0,7) not written.
- Reset mid-fill: assert rst after 20 fill cycles. Required: busy stays high, a full clear runs, and the entire row reads CLEAR_VAL afterward.

Source files
------------

// File: rtl/mem2d_param.sv
// Parametrised 2-D memory addressed by (x, y) with registered read port,
// self-clearing initialisation after reset and a hardware row-fill mode.
module mem2d_param #(
    parameter int unsigned         DATA_W    = 8,
    parameter int unsigned         X_W       = 6,
    parameter int unsigned         Y_W       = 5,
    parameter logic [DATA_W-1:0]   CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_W-1:0]    addr_x,
    input  logic [Y_W-1:0]    addr_y,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              rd,
    input  logic              fill_row,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int unsigned A_W = X_W + Y_W;

    typedef enum logic [1:0] {CLEAR, IDLE, FILL} state_t;

    state_t              state, state_nx;
    logic [A_W-1:0]      clr_cnt;
    logic [X_W-1:0]      col;
    logic [Y_W-1:0]      fill_y;
    logic [DATA_W-1:0]   fill_data;
    logic [DATA_W-1:0]   mem [(1 << A_W)];

    logic [A_W-1:0]      cmd_addr;
    logic                cmd_ok;
    logic                fill_go;
    logic                we;
    logic [A_W-1:0]      waddr;
    logic [DATA_W-1:0]   wdata;

    assign cmd_addr = {addr_y, addr_x};
    assign cmd_ok   = (state == IDLE);
    assign fill_go  = cmd_ok && fill_row;

    // State register; reset overrides any state, aborting a fill in progress.
    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (&clr_cnt) state_nx = IDLE;
            IDLE:    if (fill_row) state_nx = FILL;
            FILL:    if (&col)     state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    // Output / write-port decode: a single write port shared by clear, fill and host writes.
    always_comb begin
        busy  = (state != IDLE);
        we    = 1'b0;
        waddr = cmd_addr;
        wdata = data_in;
        if (!rst) begin
            case (state)
                CLEAR: begin
                    we    = 1'b1;
                    waddr = clr_cnt;
                    wdata = CLEAR_VAL;
                end
                IDLE: begin
                    we = wr && !fill_row;
                end
                FILL: begin
                    we    = 1'b1;
                    waddr = {fill_y, col};
                    wdata = fill_data;
                end
                default: we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
            col     <= '0;
        end else begin
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
            if (fill_go)            col <= '0;
            else if (state == FILL) col <= col + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_go) begin
            fill_y    <= addr_y;
            fill_data <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read samples the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= cmd_ok && rd;
            if (cmd_ok && rd) data_out <= mem[cmd_addr];
        end
    end

endmodule

// File: tb/tb_mem2d_param.sv
// Directed bench for mem2d_param: cycle-level model for the default instance,
// plus a small-geometry instance exercising clear with a non-zero CLEAR_VAL.
module tb_mem2d_param;

    localparam int XN = 64;
    localparam int YN = 32;
    localparam int NC = XN * YN;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic       rst = 1'b0;
    logic [5:0] ax = '0;
    logic [4:0] ay = '0;
    logic [7:0] din = '0;
    logic       wr = 1'b0, rd = 1'b0, fr = 1'b0;
    logic [7:0] dout;
    logic       rv, bsy;

    // small instance
    logic       s_rst = 1'b1;
    logic [1:0] sx = '0, sy = '0;
    logic [7:0] s_din = '0;
    logic       s_wr = 1'b0, s_rd = 1'b0, s_fr = 1'b0;
    logic [7:0] s_dout;
    logic       s_rv, s_bsy;

    int checks = 0;
    int failures = 0;

    mem2d_param dut (
        .clk(clk), .rst(rst), .addr_x(ax), .addr_y(ay), .data_in(din),
        .wr(wr), .rd(rd), .fill_row(fr),
        .data_out(dout), .rd_valid(rv), .busy(bsy)
    );

    mem2d_param #(.DATA_W(8), .X_W(2), .Y_W(2), .CLEAR_VAL(8'h5A)) dut_s (
        .clk(clk), .rst(s_rst), .addr_x(sx), .addr_y(sy), .data_in(s_din),
        .wr(s_wr), .rd(s_rd), .fill_row(s_fr),
        .data_out(s_dout), .rd_valid(s_rv), .busy(s_bsy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: memory as a flat array, outstanding busy work as remaining-cycle counts.
    logic [7:0] mm [NC];
    bit         armed = 0;
    int         clear_left = 0;
    int         fill_left = 0;
    int         fy = 0;
    logic [7:0] fd = '0;
    logic       e_valid = 1'b0;
    logic [7:0] e_dout = '0;
    int         idx;

    always @(posedge clk) begin
        idx = int'(ay) * XN + int'(ax);
        if (rst) begin
            armed      = 1;
            e_valid    = 1'b0;
            e_dout     = '0;
            clear_left = NC;
            fill_left  = 0;
        end else if (armed) begin
            e_valid = 1'b0;
            if (clear_left > 0) begin
                mm[NC - clear_left] = 8'h00;
                clear_left--;
            end else if (fill_left > 0) begin
                mm[fy * XN + (XN - fill_left)] = fd;
                fill_left--;
            end else begin
                if (rd) begin
                    e_valid = 1'b1;
                    e_dout  = mm[idx];
                end
                if (fr) begin
                    fy        = int'(ay);
                    fd        = din;
                    fill_left = XN;
                end else if (wr) begin
                    mm[idx] = din;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 32'(bsy), 32'((clear_left > 0) || (fill_left > 0)));
            chk("rd_valid", 32'(rv), 32'(e_valid));
            chk("data_out", 32'(dout), 32'(e_dout));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic w, input logic r, input logic f,
                          input logic [5:0] x, input logic [4:0] y, input logic [7:0] d);
        wr = w; rd = r; fr = f; ax = x; ay = y; din = d;
        cyc();
        wr = 1'b0; rd = 1'b0; fr = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [5:0] x, input logic [4:0] y,
                          input logic [7:0] exp);
        do_cmd(1'b0, 1'b1, 1'b0, x, y, 8'h00);
        chk({nm, "_valid"}, 32'(rv), 32'd1);
        chk(nm, 32'(dout), 32'(exp));
    endtask

    // Counts edges until busy drops, bounded by limit.
    task automatic wait_idle(output int n, input int limit);
        n = 0;
        do begin
            cyc();
            n++;
        end while (bsy && n < limit);
    endtask

    int n;
    int bad;

    initial begin
        // reset / clear of default instance
        rst = 1'b1;
        repeat (3) cyc();
        chk("reset_busy", 32'(bsy), 32'd1);
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_valid", 32'(rv), 32'd0);
        rst = 1'b0;
        wait_idle(n, NC + 100);
        chk("clear_edges", 32'(n), 32'd2048);

        // write / read
        do_cmd(1'b1, 1'b0, 1'b0, 6'd10, 5'd5, 8'hAA);
        rd_chk("wr_rd", 6'd10, 5'd5, 8'hAA);
        rd_chk("neighbour", 6'd11, 5'd5, 8'h00);
        cyc();
        chk("valid_drop", 32'(rv), 32'd0);

        // read-first collision, then back-to-back reads
        do_cmd(1'b1, 1'b0, 1'b0, 6'd1, 5'd1, 8'h11);
        do_cmd(1'b1, 1'b1, 1'b0, 6'd1, 5'd1, 8'h22);
        chk("rf_old", 32'(dout), 32'h11);
        rd_chk("rf_new", 6'd1, 5'd1, 8'h22);
        rd_chk("b2b", 6'd10, 5'd5, 8'hAA);

        // row fill with neighbouring rows preloaded and a mid-fill write
        do_cmd(1'b1, 1'b0, 1'b0, 6'd5, 5'd2, 8'h77);
        do_cmd(1'b1, 1'b0, 1'b0, 6'd5, 5'd4, 8'h44);
        do_cmd(1'b0, 1'b0, 1'b1, 6'd0, 5'd3, 8'hC3);
        chk("fill_busy_start", 32'(bsy), 32'd1);
        repeat (10) cyc();
        do_cmd(1'b1, 1'b1, 1'b0, 6'd0, 5'd3, 8'h99);
        chk("fill_rd_ignored", 32'(rv), 32'd0);
        wait_idle(n, 200);
        chk("fill_edges_rest", 32'(n), 32'd53);
        bad = 0;
        for (int x = 0; x < XN; x++) begin
            do_cmd(1'b0, 1'b1, 1'b0, 6'(x), 5'd3, 8'h00);
            if (dout !== 8'hC3) bad++;
        end
        chk("row3_filled_bad", 32'(bad), 32'd0);
        rd_chk("row2_kept", 6'd5, 5'd2, 8'h77);
        rd_chk("row4_kept", 6'd5, 5'd4, 8'h44);

        // fill_row beats wr; rd alongside fill returns pre-fill data
        do_cmd(1'b1, 1'b0, 1'b1, 6'd0, 5'd7, 8'hFF);
        wait_idle(n, 200);
        chk("fill_edges", 32'(n), 32'd64);
        rd_chk("prio_cell", 6'd0, 5'd7, 8'hFF);
        rd_chk("prio_last", 6'd63, 5'd7, 8'hFF);
        do_cmd(1'b0, 1'b1, 1'b1, 6'd2, 5'd3, 8'h5C);
        chk("fill_rd_old", 32'(dout), 32'hC3);
        wait_idle(n, 200);
        rd_chk("refill", 6'd2, 5'd3, 8'h5C);

        // reset mid-fill
        do_cmd(1'b0, 1'b0, 1'b1, 6'd0, 5'd9, 8'hE1);
        repeat (20) cyc();
        rst = 1'b1;
        cyc();
        chk("midfill_rst_busy", 32'(bsy), 32'd1);
        chk("midfill_rst_valid", 32'(rv), 32'd0);
        rst = 1'b0;
        wait_idle(n, NC + 100);
        chk("midfill_clear_edges", 32'(n), 32'd2048);
        bad = 0;
        for (int x = 0; x < XN; x++) begin
            do_cmd(1'b0, 1'b1, 1'b0, 6'(x), 5'd9, 8'h00);
            if (dout !== 8'h00) bad++;
        end
        chk("row9_cleared_bad", 32'(bad), 32'd0);

        // small instance: clear, poison, clear again with CLEAR_VAL=5A
        repeat (3) cyc();
        chk("s_reset_busy", 32'(s_bsy), 32'd1);
        s_rst = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (s_bsy && n < 100);
        chk("s_clear1_edges", 32'(n), 32'd16);
        s_wr = 1'b1; s_din = 8'hEE;
        for (int i = 0; i < 16; i++) begin
            sx = 2'(i); sy = 2'(i >> 2);
            cyc();
        end
        s_wr = 1'b0;
        s_rd = 1'b1; sx = 2'd3; sy = 2'd2;
        cyc();
        s_rd = 1'b0;
        chk("s_poisoned", 32'(s_dout), 32'hEE);
        s_rst = 1'b1;
        repeat (3) cyc();
        chk("s_reset_dout", 32'(s_dout), 32'd0);
        s_rst = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (s_bsy && n < 100);
        chk("s_clear2_edges", 32'(n), 32'd16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            s_rd = 1'b1; sx = 2'(i); sy = 2'(i >> 2);
            cyc();
            if (s_rv !== 1'b1 || s_dout !== 8'h5A) bad++;
        end
        s_rd = 1'b0;
        chk("s_all_5A_bad", 32'(bad), 32'd0);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
